// File: rtl/serial_result_receiver_if.sv
// serial_result_receiver_if: serial result link, consumer handshake and decoded outputs.
// Optional RX_FRAME_COUNT_EN adds the GoodCount/ErrCount statistics signals.
`default_nettype none

interface serial_result_receiver_if;
    logic        DataOut;
    logic        DOutValid;
    logic        ClkTx;
    logic        RxAck;
    logic [31:0] RxWord;
    logic [7:0]  RxA;
    logic [7:0]  RxB;
    logic [7:0]  RxResult;
    logic [3:0]  RxFlag;
    logic [3:0]  RxSel;
    logic        RxValid;
    logic        FrameErr;
    logic        Overrun;
    logic        RxBusy;
`ifdef RX_FRAME_COUNT_EN
    logic [15:0] GoodCount;
    logic [15:0] ErrCount;
`endif

    // Transmitter plus consumer side.
    modport master (
        output DataOut, DOutValid, ClkTx, RxAck,
        input  RxWord, RxA, RxB, RxResult, RxFlag, RxSel,
        input  RxValid, FrameErr, Overrun, RxBusy
`ifdef RX_FRAME_COUNT_EN
        , input GoodCount, ErrCount
`endif
    );

    // Receiver side.
    modport slave (
        input  DataOut, DOutValid, ClkTx, RxAck,
        output RxWord, RxA, RxB, RxResult, RxFlag, RxSel,
        output RxValid, FrameErr, Overrun, RxBusy
`ifdef RX_FRAME_COUNT_EN
        , output GoodCount, ErrCount
`endif
    );
endinterface

`default_nettype wire

// File: rtl/serial_result_receiver.sv
// serial_result_receiver: synchronises the serial result link, shifts in 32-bit words MSB first
// and delivers them over a valid/ack handshake. Optional macro RX_FRAME_COUNT_EN adds frame counters.
`default_nettype none

module serial_result_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input wire                       Clk,
    input wire                       Reset,
    serial_result_receiver_if.slave  link
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic [SYNC_STAGES-1:0] vld_sync_q;
    logic [SYNC_STAGES-1:0] ctx_sync_q;
    logic                   ctx_prev_q;
    logic [5:0]             cnt_q;
    logic [TW-1:0]          tmo_q;
    logic [31:0]            shift_q;
    logic [31:0]            rx_word_q;
    logic [7:0]             rx_a_q;
    logic [7:0]             rx_b_q;
    logic [7:0]             rx_res_q;
    logic [3:0]             rx_flag_q;
    logic [3:0]             rx_sel_q;
    logic                   rx_valid_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   busy_q;

    logic                   dat_s;
    logic                   vld_s;
    logic                   edge_s;
    logic [31:0]            shift_d;
    logic                   load_d;
    logic                   abort_d;

    assign dat_s   = dat_sync_q[SYNC_STAGES-1];
    assign vld_s   = vld_sync_q[SYNC_STAGES-1];
    assign edge_s  = ctx_sync_q[SYNC_STAGES-1] & ~ctx_prev_q;
    assign shift_d = {shift_q[30:0], dat_s};
    assign load_d  = (state_q == DONE) && (!rx_valid_q || link.RxAck);
    // A frame dies when the qualifier drops, or when the bit clock stalls too long.
    assign abort_d = (state_q == RECV) && (!vld_s || (!edge_s && (tmo_q == TMO_LAST)));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            dat_sync_q  <= '0;
            vld_sync_q  <= '0;
            ctx_sync_q  <= '0;
            ctx_prev_q  <= 1'b0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            shift_q     <= '0;
            rx_word_q   <= '0;
            rx_a_q      <= '0;
            rx_b_q      <= '0;
            rx_res_q    <= '0;
            rx_flag_q   <= '0;
            rx_sel_q    <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], link.DataOut};
            vld_sync_q  <= {vld_sync_q[SYNC_STAGES-2:0], link.DOutValid};
            ctx_sync_q  <= {ctx_sync_q[SYNC_STAGES-2:0], link.ClkTx};
            ctx_prev_q  <= ctx_sync_q[SYNC_STAGES-1];
            frame_err_q <= abort_d;

            // A load in DONE below overrides this clear.
            if (link.RxAck && rx_valid_q) begin
                rx_valid_q <= 1'b0;
                overrun_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (vld_s) begin
                        state_q <= RECV;
                        busy_q  <= 1'b1;
                        tmo_q   <= '0;
                        if (edge_s) begin
                            shift_q <= shift_d;
                            cnt_q   <= 6'd1;
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                end
                RECV: begin
                    if (abort_d) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (edge_s) begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + 6'd1;
                        tmo_q   <= '0;
                        if (cnt_q == 6'd31) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                DONE: begin
                    if (load_d) begin
                        rx_word_q  <= shift_q;
                        rx_a_q     <= shift_q[31:24];
                        rx_b_q     <= shift_q[23:16];
                        rx_res_q   <= shift_q[15:8];
                        rx_flag_q  <= shift_q[7:4];
                        rx_sel_q   <= shift_q[3:0];
                        rx_valid_q <= 1'b1;
                    end else begin
                        overrun_q  <= 1'b1;
                    end
                    cnt_q <= '0;
                    tmo_q <= '0;
                    if (vld_s) begin
                        state_q <= RECV;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RX_FRAME_COUNT_EN
    logic [15:0] good_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (load_d)  good_cnt_q <= good_cnt_q + 16'd1;
            if (abort_d) err_cnt_q  <= err_cnt_q + 16'd1;
        end
    end

    assign link.GoodCount = good_cnt_q;
    assign link.ErrCount  = err_cnt_q;
`endif

    assign link.RxWord   = rx_word_q;
    assign link.RxA      = rx_a_q;
    assign link.RxB      = rx_b_q;
    assign link.RxResult = rx_res_q;
    assign link.RxFlag   = rx_flag_q;
    assign link.RxSel    = rx_sel_q;
    assign link.RxValid  = rx_valid_q;
    assign link.FrameErr = frame_err_q;
    assign link.Overrun  = overrun_q;
    assign link.RxBusy   = busy_q;
endmodule

`default_nettype wire

// File: tb/tb_serial_result_receiver.sv
// tb_serial_result_receiver: directed frames against a link-level reference model of the receiver.
`default_nettype none

module tb_serial_result_receiver;
    localparam int S = 2;
    localparam int T = 1024;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    serial_result_receiver_if link ();

    serial_result_receiver #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .link  (link)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: the link as seen S cycles late, plus frame/handshake bookkeeping.
    bit          hd [0:S+1];
    bit          hv [0:S+1];
    bit          hc [0:S+1];
    bit          m_in_frame, m_pending, m_valid, m_ovr, m_ferr;
    int          m_bits, m_idle;
    logic [31:0] m_shift, m_word;
    logic [15:0] m_good, m_errc;

    int          ferr_pulses = 0;
    int          ferr_hi = 0;
    int          busy_low = 0;
    bit          prev_valid = 0;
    logic [31:0] got[$];

    task automatic model_reset();
        for (int j = 0; j <= S + 1; j++) begin
            hd[j] = 0; hv[j] = 0; hc[j] = 0;
        end
        m_in_frame = 0; m_pending = 0; m_valid = 0; m_ovr = 0; m_ferr = 0;
        m_bits = 0; m_idle = 0; m_shift = '0; m_word = '0; m_good = '0; m_errc = '0;
    endtask

    task automatic take_bit(bit d);
        m_shift = (m_shift << 1) | 32'(d);
        m_bits  = m_bits + 1;
        m_idle  = 0;
    endtask

    task automatic abort_frame();
        m_ferr = 1; m_in_frame = 0; m_errc = m_errc + 16'd1;
    endtask

    task automatic model_step(bit din, bit vin, bit cin, bit ack);
        bit d, v, e;
        for (int j = S + 1; j > 0; j--) begin
            hd[j] = hd[j-1]; hv[j] = hv[j-1]; hc[j] = hc[j-1];
        end
        hd[0] = din; hv[0] = vin; hc[0] = cin;
        d = hd[S]; v = hv[S]; e = hc[S] && !hc[S+1];
        m_ferr = 0;
        if (m_pending) begin
            m_pending = 0;
            if (!m_valid || ack) begin
                m_word  = m_shift;
                m_valid = 1;
                if (ack) m_ovr = 0;
                m_good  = m_good + 16'd1;
            end else begin
                m_ovr = 1;
            end
            m_in_frame = v; m_bits = 0; m_idle = 0;
        end else begin
            if (ack && m_valid) begin m_valid = 0; m_ovr = 0; end
            if (!m_in_frame) begin
                if (v) begin
                    m_in_frame = 1; m_bits = 0; m_idle = 0;
                    if (e) take_bit(d);
                end
            end else if (!v) begin
                abort_frame();
            end else if (e) begin
                take_bit(d);
                if (m_bits == 32) begin m_pending = 1; m_in_frame = 0; end
            end else if (m_idle == T - 1) begin
                abort_frame();
            end else begin
                m_idle = m_idle + 1;
            end
        end
    endtask

    // Cycle-by-cycle comparison against the model, sampled 1 time unit after each edge.
    always @(posedge Clk) begin
        logic [71:0] act_w, exp_w;
        logic [35:0] act_c, exp_c;
        bit din, vin, cin, ack;
        din = link.DataOut; vin = link.DOutValid; cin = link.ClkTx; ack = link.RxAck;
        if (!Reset) model_reset();
        else model_step(din, vin, cin, ack);
        #1;
        act_w = {link.RxWord, link.RxA, link.RxB, link.RxResult, link.RxFlag, link.RxSel};
        exp_w = {m_word, m_word[31:24], m_word[23:16], m_word[15:8], m_word[7:4], m_word[3:0]};
        n_cmp++;
        if (act_w !== exp_w) begin
            n_err++;
            $display("FAIL word t=%0t got=%h expected=%h", $time, act_w, exp_w);
        end
`ifdef RX_FRAME_COUNT_EN
        act_c = {link.RxValid, link.Overrun, link.FrameErr, link.RxBusy, link.GoodCount, link.ErrCount};
        exp_c = {m_valid, m_ovr, m_ferr, m_in_frame, m_good, m_errc};
`else
        act_c = {link.RxValid, link.Overrun, link.FrameErr, link.RxBusy, 32'h0};
        exp_c = {m_valid, m_ovr, m_ferr, m_in_frame, 32'h0};
`endif
        n_cmp++;
        if (act_c !== exp_c) begin
            n_err++;
            $display("FAIL ctrl t=%0t got=%h expected=%h", $time, act_c, exp_c);
        end
        if (link.FrameErr) ferr_hi++;
        if (link.FrameErr && ferr_hi == 1 + ferr_pulses) ferr_pulses++;
        if (!link.FrameErr) ferr_hi = ferr_pulses;
        if (Reset && !link.RxBusy) busy_low++;
        if (link.RxValid && !prev_valid) got.push_back(link.RxWord);
        prev_valid = link.RxValid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Sends nbits MSB first with ClkTx = Clk/8; end_frame drops DOutValid just after the last rise.
    task automatic drive_bits(input logic [31:0] w, input int nbits, input bit end_frame);
        link.DOutValid = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            link.DataOut = w[31-i];
            link.ClkTx   = 1'b0;
            wait_cycles(4);
            link.ClkTx   = 1'b1;
            if (end_frame && i == nbits - 1) begin
                wait_cycles(1);
                link.DOutValid = 1'b0;
                wait_cycles(3);
                link.ClkTx = 1'b0;
            end else begin
                wait_cycles(4);
            end
        end
    endtask

    task automatic ack_pulse();
        link.RxAck = 1'b1;
        wait_cycles(1);
        link.RxAck = 1'b0;
    endtask

    initial begin
        int p0, b0;
        logic [15:0] g0, e0;
        link.DataOut = 0; link.DOutValid = 0; link.ClkTx = 0; link.RxAck = 0;
        g0 = '0; e0 = '0;
        wait_cycles(3);
        chk("reset_valid", 32'(link.RxValid), 32'h0);
        chk("reset_word", link.RxWord, 32'h0);
        Reset = 1'b1;
        wait_cycles(2);

        // Plain frame, left unacknowledged so the reset below has state to clear.
        drive_bits(32'hAB55_0010, 32, 1);
        wait_cycles(4);
        chk("f1_valid", 32'(link.RxValid), 32'h1);
        chk("f1_RxA", 32'(link.RxA), 32'hAB);
        chk("f1_RxB", 32'(link.RxB), 32'h55);
        chk("f1_RxResult", 32'(link.RxResult), 32'h00);
        chk("f1_RxFlag", 32'(link.RxFlag), 32'h1);
        chk("f1_RxSel", 32'(link.RxSel), 32'h0);

        // Asynchronous reset 10 bits into a frame.
        drive_bits(32'h1234_5678, 10, 0);
        #2 Reset = 1'b0;
        link.DOutValid = 0; link.ClkTx = 0; link.DataOut = 0;
        #1;
        chk("async_rst_out", {link.RxValid, link.Overrun, link.FrameErr, link.RxBusy, link.RxA, link.RxSel},
            32'h0);
        chk("async_rst_word", link.RxWord, 32'h0);
        wait_cycles(2);
        Reset = 1'b1;
        wait_cycles(2);
        drive_bits(32'hAB55_0010, 32, 1);
        wait_cycles(4);
        chk("post_rst_word", link.RxWord, 32'hAB55_0010);
        ack_pulse();
        chk("ack_clears_valid", 32'(link.RxValid), 32'h0);

        // Truncated frame.
        p0 = ferr_pulses;
        drive_bits(32'hDEAD_BEEF, 20, 0);
        link.ClkTx = 0; link.DOutValid = 0;
        wait_cycles(10);
        chk("trunc_ferr_pulses", 32'(ferr_pulses - p0), 32'h1);
        chk("trunc_no_valid", 32'(link.RxValid), 32'h0);
        drive_bits(32'hFFC0_3F01, 32, 1);
        wait_cycles(4);
        chk("after_trunc_word", link.RxWord, 32'hFFC0_3F01);
        ack_pulse();

        // Back-to-back with no acknowledge: second word is dropped.
        drive_bits(32'h1234_5678, 32, 0);
        drive_bits(32'h9ABC_DEF0, 32, 1);
        wait_cycles(4);
        chk("ovr_word", link.RxWord, 32'h1234_5678);
        chk("ovr_flag", 32'(link.Overrun), 32'h1);
        ack_pulse();
        chk("ovr_ack_clear", {30'h0, link.RxValid, link.Overrun}, 32'h0);
        ack_pulse();
        chk("idle_ack_no_effect", 32'(link.RxValid), 32'h0);

        // Stalled bit clock with DOutValid held high.
        p0 = ferr_pulses;
        drive_bits(32'h5A5A_A5A5, 10, 0);
        link.ClkTx = 0;
        b0 = busy_low;
        wait_cycles(T + 10);
        chk("timeout_ferr", 32'(ferr_pulses - p0), 32'h1);
        chk("timeout_busy_fell", 32'(busy_low > b0), 32'h1);
        link.DOutValid = 0;
        wait_cycles(10);

        // Back-to-back with RxAck held through both DONE cycles.
`ifdef RX_FRAME_COUNT_EN
        g0 = link.GoodCount; e0 = link.ErrCount;
`endif
        got.delete();
        link.RxAck = 1'b1;
        drive_bits(32'h0F0F_1234, 32, 0);
        drive_bits(32'hCAFE_0042, 32, 1);
        wait_cycles(4);
        link.RxAck = 1'b0;
        chk("b2b_count", 32'(got.size()), 32'h2);
        chk("b2b_first", (got.size() > 0) ? got[0] : 32'hX, 32'h0F0F_1234);
        chk("b2b_second", (got.size() > 1) ? got[1] : 32'hX, 32'hCAFE_0042);
        chk("b2b_no_overrun", 32'(link.Overrun), 32'h0);
`ifdef RX_FRAME_COUNT_EN
        chk("good_count_delta", 32'(link.GoodCount - g0), 32'h2);
        chk("err_count_delta", 32'(link.ErrCount - e0), 32'h0);
`endif
        wait_cycles(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
